// File: rtl/manchester_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_pkg
//  Description : Shared types and interval-bound helpers for the Manchester
//                decoder (FSM states, interval classes, class bounds).
//  Revision    : 1.0 - initial release
// ============================================================================
package manchester_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        ACQUIRE  = 2'd1,
        MID      = 2'd2,
        BOUNDARY = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SHORT   = 2'd0,
        LONG    = 2'd1,
        INVALID = 2'd2
    } iclass_t;

    // Half-bit interval bounds (inclusive)
    function automatic int short_min(input int half_bit, input int tol);
        return half_bit - tol;
    endfunction

    function automatic int short_max(input int half_bit, input int tol);
        return half_bit + tol;
    endfunction

    // Full-bit interval bounds (inclusive)
    function automatic int long_min(input int half_bit, input int tol);
        return 2 * half_bit - tol;
    endfunction

    function automatic int long_max(input int half_bit, input int tol);
        return 2 * half_bit + tol;
    endfunction

    // First interval length that can no longer be a valid long interval
    function automatic int timeout_cycles(input int half_bit, input int tol);
        return 2 * half_bit + tol + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_decoder_edge_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : edge_interval_timer
//  Description : Saturating elapsed-cycle counter restarted on every line
//                edge, interval classifier (SHORT/LONG/INVALID) and line-idle
//                timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_interval_timer
    import manchester_pkg::*;
#(
    parameter int HALF_BIT = 8,
    parameter int TOL      = 2,
    parameter int CNT_W    = 16
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    i_any_edge,
    output iclass_t o_interval_class,
    output logic    o_timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W:0]   c_short_min = (CNT_W+1)'(short_min(HALF_BIT, TOL));
    localparam logic [CNT_W:0]   c_short_max = (CNT_W+1)'(short_max(HALF_BIT, TOL));
    localparam logic [CNT_W:0]   c_long_min  = (CNT_W+1)'(long_min(HALF_BIT, TOL));
    localparam logic [CNT_W:0]   c_long_max  = (CNT_W+1)'(long_max(HALF_BIT, TOL));
    localparam logic [CNT_W:0]   c_timeout   = (CNT_W+1)'(timeout_cycles(HALF_BIT, TOL));

    generate
        if (2 * TOL >= HALF_BIT) begin : g_bad_tol
            $error("edge_interval_timer: 2*TOL must be smaller than HALF_BIT");
        end
        if ($clog2(timeout_cycles(HALF_BIT, TOL) + 1) > CNT_W) begin : g_bad_cnt_w
            $error("edge_interval_timer: CNT_W too narrow for the timeout count");
        end
    endgenerate

    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W:0]   w_interval;

    // Cycles since the last edge; restarts on each edge, sticks at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            r_elapsed <= '0;
        end else if (i_any_edge) begin
            r_elapsed <= '0;
        end else if (r_elapsed != c_cnt_max) begin
            r_elapsed <= r_elapsed + 1'b1;
        end
    end

    // The counter reads I-1 in the cycle an edge arrives I cycles after the last one
    assign w_interval = {1'b0, r_elapsed} + {{CNT_W{1'b0}}, 1'b1};

    // Classify the interval that an edge in this cycle would close
    always_comb begin
        o_interval_class = INVALID;
        if (w_interval >= c_short_min && w_interval <= c_short_max) begin
            o_interval_class = SHORT;
        end else if (w_interval >= c_long_min && w_interval <= c_long_max) begin
            o_interval_class = LONG;
        end
    end

    assign o_timeout = (w_interval >= c_timeout);

endmodule
`default_nettype wire

// File: rtl/manchester_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_decoder
//  Description : Manchester (IEEE 802.3 polarity) decoder. Locks on a 0,1
//                sync pair, tracks mid-bit phase, emits bits and MSB-first
//                bytes, and flags decode errors and end of frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int HALF_BIT = 8,
    parameter int TOL      = 2,
    parameter int CNT_W    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       digital_in,
    input  logic       any_edge,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_end,
    output logic       decode_error,
    output logic       locked
);

    iclass_t    w_class;
    logic       w_timeout;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_count;
    logic [2:0] w_bit_count_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic       w_emit;
    logic       w_byte_done;
    logic       w_error;
    logic       w_frame_end;

    logic       r_bit_out;
    logic       r_bit_valid;
    logic [7:0] r_byte_out;
    logic       r_byte_valid;
    logic       r_frame_end;
    logic       r_decode_error;

    edge_interval_timer #(
        .HALF_BIT (HALF_BIT),
        .TOL      (TOL),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clock            (clock),
        .reset            (reset),
        .i_any_edge       (any_edge),
        .o_interval_class (w_class),
        .o_timeout        (w_timeout)
    );

    // Phase-tracking next state, bit assembly and strobe requests
    always_comb begin
        w_state_next     = r_state;
        w_bit_count_next = r_bit_count;
        w_shift_next     = r_shift;
        w_emit           = 1'b0;
        w_byte_done      = 1'b0;
        w_error          = 1'b0;
        w_frame_end      = 1'b0;

        case (r_state)
            HUNT: begin
                if (any_edge) begin
                    w_state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                // The long interval closing on the sync '1' mid-edge fixes phase
                if (any_edge && w_class == LONG) begin
                    w_state_next     = MID;
                    w_bit_count_next = '0;
                    w_shift_next     = '0;
                end
            end
            MID: begin
                if (any_edge) begin
                    case (w_class)
                        SHORT:   w_state_next = BOUNDARY;
                        LONG:    w_emit       = 1'b1;
                        default: w_error      = 1'b1;
                    endcase
                end else if (w_timeout) begin
                    w_frame_end = 1'b1;
                end
            end
            BOUNDARY: begin
                if (any_edge) begin
                    if (w_class == SHORT) begin
                        w_state_next = MID;
                        w_emit       = 1'b1;
                    end else begin
                        w_error = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_next = HUNT;
        endcase

        // A mid-bit edge carries the bit in the new line level
        if (w_emit) begin
            w_shift_next     = {r_shift[6:0], digital_in};
            w_bit_count_next = r_bit_count + 3'd1;
            w_byte_done      = (r_bit_count == 3'd7);
        end

        // Errors restart acquisition from this edge; timeouts drop back to hunting
        if (w_error) begin
            w_state_next     = ACQUIRE;
            w_bit_count_next = '0;
            w_shift_next     = '0;
        end
        if (w_frame_end) begin
            w_state_next     = HUNT;
            w_bit_count_next = '0;
            w_shift_next     = '0;
        end
    end

    // State, assembly registers and one-cycle-latency output strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= HUNT;
            r_bit_count    <= '0;
            r_shift        <= '0;
            r_bit_out      <= 1'b0;
            r_bit_valid    <= 1'b0;
            r_byte_out     <= '0;
            r_byte_valid   <= 1'b0;
            r_frame_end    <= 1'b0;
            r_decode_error <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_bit_count    <= w_bit_count_next;
            r_shift        <= w_shift_next;
            r_bit_valid    <= w_emit;
            r_byte_valid   <= w_byte_done;
            r_frame_end    <= w_frame_end;
            r_decode_error <= w_error;
            if (w_emit) begin
                r_bit_out <= digital_in;
            end
            if (w_byte_done) begin
                r_byte_out <= w_shift_next;
            end
        end
    end

    assign bit_out      = r_bit_out;
    assign bit_valid    = r_bit_valid;
    assign byte_out     = r_byte_out;
    assign byte_valid   = r_byte_valid;
    assign frame_end    = r_frame_end;
    assign decode_error = r_decode_error;
    assign locked       = (r_state == MID) || (r_state == BOUNDARY);

endmodule
`default_nettype wire
